// File: rtl/seq1101_pkg.sv
// rtl/seq1101_pkg.sv - shared encodings for the 1101 framer and detector
package seq1101_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } mirror_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } tx_state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b1101;

endpackage

// File: rtl/seq1101_framer_tx_if.sv
// rtl/seq1101_framer_tx_if.sv - word handshake and serial output bundle of the framer
interface seq1101_framer_tx_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx_out;
  logic              tx_en;
  logic              stuff_flag;
  logic              frame_done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  tx_out,
    input  tx_en,
    input  stuff_flag,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output tx_out,
    output tx_en,
    output stuff_flag,
    output frame_done
  );

endinterface

// File: rtl/seq1101_mirror.sv
// rtl/seq1101_mirror.sv - one step of the non-overlapping Mealy 1101 detector
module seq1101_mirror
  import seq1101_pkg::*;
(
  input  mirror_state_t state,
  input  logic          bit_in,
  output mirror_state_t next_state,
  output logic          detect
);

  always_comb begin
    next_state = S0;
    detect     = 1'b0;
    unique case (state)
      S0: next_state = bit_in ? S1 : S0;
      S1: next_state = bit_in ? S2 : S0;
      S2: next_state = bit_in ? S2 : S3;
      S3: begin
        next_state = S0;
        detect     = bit_in;
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: rtl/seq1101_framer_tx.sv
// rtl/seq1101_framer_tx.sv - 1101 sync + payload serialiser with detector-driven 0 stuffing
module seq1101_framer_tx
  import seq1101_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               reset,
  seq1101_framer_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state_q, state_d;
  mirror_state_t     mirror_q, mirror_d, mirror_base, mirror_next;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]        sync_idx_q, sync_idx_d;
  logic [1:0]        sync_bit_idx;
  logic              accept, emit, emit_bit, emit_stuff, last_bit, mirror_detect;

  assign accept = bus.in_valid && bus.in_ready && (state_q == IDLE);

  // The mirror sees the bit being registered this edge, so mirror_q always
  // reflects the detector state after the bit currently on tx_out.
  seq1101_mirror u_mirror (
    .state      (mirror_base),
    .bit_in     (emit_bit),
    .next_state (mirror_next),
    .detect     (mirror_detect)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mirror_q       <= S0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      sync_idx_q     <= '0;
      bus.in_ready   <= 1'b0;
      bus.tx_out     <= 1'b0;
      bus.tx_en      <= 1'b0;
      bus.stuff_flag <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      mirror_q       <= mirror_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      sync_idx_q     <= sync_idx_d;
      bus.in_ready   <= (state_q == IDLE) && !accept;
      bus.tx_out     <= emit_bit;
      bus.tx_en      <= emit;
      bus.stuff_flag <= emit_stuff;
      bus.frame_done <= last_bit;
    end
  end

  always_comb begin
    emit         = 1'b0;
    emit_bit     = 1'b0;
    emit_stuff   = 1'b0;
    mirror_base  = mirror_q;
    sync_bit_idx = 2'd3 - sync_idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          emit        = 1'b1;
          emit_bit    = SYNC_PATTERN[3];
          mirror_base = S0;
        end
      end
      SYNC: begin
        emit     = 1'b1;
        emit_bit = SYNC_PATTERN[sync_bit_idx];
      end
      DATA: begin
        emit = 1'b1;
        if (mirror_q == S3) begin
          emit_stuff = 1'b1;
        end else begin
          emit_bit = shift_q[DATA_W-1];
        end
      end
      TAIL: begin
        emit       = 1'b1;
        emit_stuff = (mirror_q == S3);
      end
      default: emit = 1'b0;
    endcase
    last_bit = emit && (mirror_next == S0) &&
               ((state_q == TAIL) ||
                (state_q == DATA && !emit_stuff && bit_cnt_q == CNT_W'(1)));
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sync_idx_d = sync_idx_q;
    mirror_d   = emit ? mirror_next : mirror_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SYNC;
          shift_d    = bus.in_data;
          bit_cnt_d  = CNT_W'(DATA_W);
          sync_idx_d = 2'd1;
        end
      end
      SYNC: begin
        sync_idx_d = sync_idx_q + 2'd1;
        // The 4th sync bit is the only detection a frame ever produces.
        if (mirror_detect) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (!emit_stuff) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          if (bit_cnt_q == CNT_W'(1)) begin
            state_d = last_bit ? IDLE : TAIL;
          end
        end
      end
      TAIL: begin
        if (last_bit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq1101_framer_tx.sv
// tb/tb_seq1101_framer_tx.sv - randomized self-checking bench for the 1101 framer
module tb_seq1101_framer_tx;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq1101_framer_tx_if #(.DATA_W(DATA_W)) bus ();

  seq1101_framer_tx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit exp_bits[$];
  bit exp_stuff[$];
  bit hist[$];
  bit ohist[$];
  int last_wait;
  logic [31:0] stuff_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit suffix4(input bit q[$], input logic [3:0] pat);
    int n = q.size();
    if (n < 4) return 1'b0;
    return {q[n-4], q[n-3], q[n-2], q[n-1]} == pat;
  endfunction

  function automatic bit ends_110(input bit q[$]);
    int n = q.size();
    if (n < 3) return 1'b0;
    return q[n-3] && q[n-2] && !q[n-1];
  endfunction

  // Detector modelled as a history of unconsumed bits: a 110 suffix is the
  // "stuff next" condition; 1101 or 1100 consumes the history.
  task automatic model_push(input bit b, input bit s);
    exp_bits.push_back(b);
    exp_stuff.push_back(s);
    hist.push_back(b);
    if (suffix4(hist, 4'b1101) || suffix4(hist, 4'b1100)) hist.delete();
  endtask

  function automatic bit model_busy();
    int n = hist.size();
    return (n > 0) && (hist[n-1] || ends_110(hist));
  endfunction

  task automatic model_frame(input logic [7:0] w);
    logic [3:0] pat;
    int consumed;
    pat = 4'b1101;
    exp_bits.delete();
    exp_stuff.delete();
    hist.delete();
    for (int i = 0; i < 4; i++) model_push(pat[3-i], 1'b0);
    consumed = 0;
    while (consumed < DATA_W) begin
      if (ends_110(hist)) model_push(1'b0, 1'b1);
      else begin
        model_push(w[DATA_W-1-consumed], 1'b0);
        consumed++;
      end
    end
    while (model_busy() && exp_bits.size() < 64) model_push(1'b0, ends_110(hist));
  endtask

  task automatic obs_push(input bit b, output bit det);
    ohist.push_back(b);
    det = suffix4(ohist, 4'b1101);
    if (det || suffix4(ohist, 4'b1100)) ohist.delete();
  endtask

  task automatic run_frame(input logic [7:0] w, input bit hold, input logic [7:0] w_next,
                           input int abort_at, input int exp_len);
    int waits, n, dets, det_pos;
    bit det, done;
    model_frame(w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    waits = 0;
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    last_wait = waits;
    if (waits >= 50) begin
      check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) bus.in_data = w_next;
    else bus.in_valid = 1'b0;
    ohist.delete();
    n = 0; dets = 0; det_pos = 0; done = 1'b0; stuff_mask = '0;
    while (!done && n < 64) begin
      n++;
      if (n == abort_at) begin
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("abort_tx_en", 32'(bus.tx_en), 32'd0);
        check_eq("abort_tx_out", 32'(bus.tx_out), 32'd0);
        check_eq("abort_stuff", 32'(bus.stuff_flag), 32'd0);
        check_eq("abort_ready", 32'(bus.in_ready), 32'd0);
        check_eq("abort_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_after", 32'(bus.in_ready), 32'd1);
        check_eq("abort_idle_tx_en", 32'(bus.tx_en), 32'd0);
        return;
      end
      check_eq($sformatf("bit%0d_tx_en", n), 32'(bus.tx_en), 32'd1);
      check_eq($sformatf("bit%0d_ready", n), 32'(bus.in_ready), 32'd0);
      if (n <= exp_bits.size()) begin
        check_eq($sformatf("bit%0d_tx_out", n), 32'(bus.tx_out), 32'(exp_bits[n-1]));
        check_eq($sformatf("bit%0d_stuff", n), 32'(bus.stuff_flag), 32'(exp_stuff[n-1]));
        check_eq($sformatf("bit%0d_done", n), 32'(bus.frame_done), 32'(n == exp_bits.size()));
      end
      if (bus.stuff_flag === 1'b1 && n <= 32) stuff_mask[n-1] = 1'b1;
      if (bus.tx_en === 1'b1) begin
        obs_push(bus.tx_out, det);
        if (det) begin
          dets++;
          det_pos = n;
        end
      end
      if (bus.frame_done === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    check_eq("frame_len", 32'(n), 32'(exp_bits.size()));
    if (exp_len != 0) check_eq("frame_len_plan", 32'(n), 32'(exp_len));
    check_eq("detections", 32'(dets), 32'd1);
    check_eq("detect_pos", 32'(det_pos), 32'd4);
    @(negedge clk);
    check_eq("idle_tx_en", 32'(bus.tx_en), 32'd0);
    check_eq("idle_tx_out", 32'(bus.tx_out), 32'd0);
    check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
    check_eq("idle_done", 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur, nxt;
    bit h;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    check_eq("rst_tx_out", 32'(bus.tx_out), 32'd0);
    check_eq("rst_tx_en", 32'(bus.tx_en), 32'd0);
    check_eq("rst_stuff", 32'(bus.stuff_flag), 32'd0);
    check_eq("rst_done", 32'(bus.frame_done), 32'd0);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);
    check_eq("tx_en_after_rst", 32'(bus.tx_en), 32'd0);

    run_frame(8'h00, 1'b0, 8'h00, 0, 12);
    check_eq("stuff_pos_00", stuff_mask, 32'h0);
    run_frame(8'hFF, 1'b0, 8'h00, 0, 14);
    check_eq("stuff_pos_ff", stuff_mask, 32'h0000_2000);
    run_frame(8'hD3, 1'b0, 8'h00, 0, 15);
    check_eq("stuff_pos_d3", stuff_mask, 32'h0000_4080);
    run_frame(8'h6C, 1'b0, 8'h00, 0, 14);
    check_eq("stuff_pos_6c", stuff_mask, 32'h0000_1100);

    run_frame(8'hFF, 1'b1, 8'h00, 0, 14);
    run_frame(8'h00, 1'b0, 8'h00, 0, 12);
    check_eq("b2b_gap", 32'(last_wait), 32'd0);

    repeat (2) @(negedge clk);
    run_frame(8'hD3, 1'b0, 8'h00, 7, 0);
    run_frame(8'h00, 1'b0, 8'h00, 0, 12);

    cur = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      nxt = 8'($urandom);
      h = 1'($urandom_range(0, 1));
      run_frame(cur, h, nxt, 0, 0);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
      cur = nxt;
    end
    run_frame(cur, 1'b0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
